load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address and rs2 as store data.
- Drives a word-wide request/ready data bus with byte enables, and returns sign- or zero-extended load data to writeback.
- Stalls the single-cycle core with a stall signal until the access completes; flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255, number of BUSY cycles without bus_ready before an error completion; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- lsu_valid  input  1  the current instruction is a load or store.
- mem_read  input  1  load.
- mem_write  input  1  store; has priority if both mem_read and mem_write are set.
- funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  effective address (ALUResult).
- wdata  input  32  store data (rs2).
- lsu_stall  output  1  holds PC and register writes while high.
- lsu_rdata  output  32  extended load result, registered.
- lsu_err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word address; bits [1:0] always 0.
- bus_wdata  output  32  lane-replicated store data.
- bus_be  output  4  byte enables.
- bus_ready  input  1  bus accepts or completes the access this cycle.
- bus_rdata  input  32  read word; valid when bus_ready is high.

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE; counter clears.
  - Every output is 0: lsu_stall, lsu_rdata, lsu_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be.
  - Reset asserted mid-access drops bus_req immediately; the access is abandoned.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Request = lsu_valid & (mem_read | mem_write).
  - Legal request (W requires addr[1:0]=0; H/HU requires addr[0]=0; funct3 in the legal set):
    - lsu_stall=1 combinationally in the same cycle.
    - Next edge: register bus_req=1, bus_we, bus_addr={addr[31:2],2'b00}, bus_wdata, bus_be; go to BUSY.
  - Misaligned or illegal request:
    - No bus access; lsu_stall stays 0.
    - lsu_err=1 combinationally for that cycle; state stays IDLE.
- BUSY:
  - lsu_stall=1.
  - All bus_* outputs are held stable until bus_ready is sampled high.
  - On bus_ready: bus_req=0 next edge. For a load, lsu_rdata is captured from the extended bus_rdata. Go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 and no bus_ready arrives: drop bus_req, set lsu_rdata=0, go to DONE with error.
- DONE:
  - lsu_stall=0; the core commits and advances this cycle.
  - lsu_err=1 only if the access timed out.
  - Request inputs are ignored because they still belong to the retiring instruction.
  - Always goes to IDLE next edge; the counter clears.
- Latency: with bus_ready in the first BUSY cycle, the request cycle and the BUSY cycle stall; DONE is the third cycle. Total is 3 cycles, 2 of them stalled.
- Store lanes:
  - B: bus_wdata = the byte replicated to all 4 lanes; bus_be = 1<<addr[1:0].
  - H: bus_wdata = the halfword replicated to both halves; bus_be = 0011 if addr[1]=0, else 1100.
  - W: bus_be = 1111.
- Load extract:
  - B/BU: select byte addr[1:0]; sign- or zero-extend to 32 bits.
  - H/HU: select half addr[1]; sign- or zero-extend to 32 bits.
  - W: pass-through.
- The lane and extract data path is computed from addr and funct3 captured at BUSY entry, not from live inputs.
- lsu_rdata holds its value until the next completed load; stores do not modify it.

Decomposition:
- lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Byte-enable constants.
- One combinational sub-module, lsu_lane_align:
  - Store lane replication and bus_be generation.
  - Load byte/half selection and extension.
- The FSM, counter and registers stay in the top module.

Test Plan:
- LB, addr=0x1003, bus_rdata=0x80FF_FF01 with ready in the first BUSY cycle:
  - bus_addr=0x1000, bus_be=1000; lsu_rdata=0xFFFFFF80.
  - lsu_stall high for 2 cycles, low in DONE.
- LHU, addr=0x2002, bus_rdata=0xBEEF_1234: lsu_rdata=0x0000BEEF.
  - Same address with LH: lsu_rdata=0xFFFFBEEF.
- SB, addr=0x11, wdata=0xAB:
  - bus_we=1, bus_addr=0x10, bus_wdata=0xABABABAB, bus_be=0010.
  - SH to addr 0x12 with wdata 0x1234: bus_be=1100, bus_wdata=0x12341234.
- LW addr=0x6 and SH addr=0x3:
  - lsu_err pulses in the request cycle; no bus_req; lsu_stall=0.
  - funct3=011 also gives lsu_err and no bus_req.
- LW with bus_ready withheld, TIMEOUT_CYCLES=4:
  - bus_req and bus_addr stay stable for 4 BUSY cycles, then DONE.
  - lsu_err=1 and lsu_rdata=0.
  - TIMEOUT_CYCLES=0 with 20 wait cycles instead completes normally.
- SW in BUSY, rst_n pulled low asynchronously:
  - bus_req and lsu_stall drop before the next clock edge.
  - After release, the FSM is in IDLE and all outputs are 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states,
// byte-enable patterns and the request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_W:        ok = (off == 2'b00);
            F3_H, F3_HU: ok = (off[0] == 1'b0);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data replication and byte enables,
// plus load byte/half selection with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_lanes,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_ext
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    assign ld_byte_s = ld_word[{ld_off, 3'b000} +: 8];
    assign ld_half_s = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    // Store side: replicate the datum across lanes, enable only the addressed bytes
    always_comb begin
        st_lanes = 32'h0000_0000;
        st_be    = BE_NONE;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_lanes = {4{st_wdata[7:0]}};
                st_be    = BE_BYTE0 << st_off;
            end
            F3_H, F3_HU: begin
                st_lanes = {2{st_wdata[15:0]}};
                st_be    = st_off[1] ? BE_HI_HALF : BE_LO_HALF;
            end
            F3_W: begin
                st_lanes = st_wdata;
                st_be    = BE_ALL;
            end
            default: begin
                st_lanes = 32'h0000_0000;
                st_be    = BE_NONE;
            end
        endcase
    end

    // Load side: extend the selected byte/half to a full register value
    always_comb begin
        ld_ext = 32'h0000_0000;
        case (ld_funct3)
            F3_B:    ld_ext = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_BU:   ld_ext = {24'h00_0000, ld_byte_s};
            F3_H:    ld_ext = {{16{ld_half_s[15]}}, ld_half_s};
            F3_HU:   ld_ext = {16'h0000, ld_half_s};
            F3_W:    ld_ext = ld_word;
            default: ld_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns ALU address + rs2 into a word-bus transaction,
// stalls the core until it completes, and flags bad or timed-out accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             to_err_q, to_err_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;

    logic             req_s;
    logic             legal_s;
    logic [31:0]      st_lanes_s;
    logic [3:0]       st_be_s;
    logic [31:0]      ld_ext_s;

    assign req_s   = lsu_valid && (mem_read || mem_write);
    assign legal_s = f3_legal(funct3) && addr_aligned(funct3, addr[1:0]);

    lsu_lane_align u_lane_align (
        .st_funct3 (funct3),
        .st_off    (addr[1:0]),
        .st_wdata  (wdata),
        .st_lanes  (st_lanes_s),
        .st_be     (st_be_s),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_word   (bus_rdata),
        .ld_ext    (ld_ext_s)
    );

    // Next-state and next-register computation for the access FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rdata_d     = rdata_q;
        to_err_d    = to_err_q;
        f3_d        = f3_q;
        off_d       = off_q;
        case (state_q)
            IDLE: begin
                if (req_s && legal_s) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = mem_write ? st_lanes_s : 32'h0000_0000;
                    bus_be_d    = st_be_s;
                    f3_d        = funct3;
                    off_d       = addr[1:0];
                    to_err_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    to_err_d  = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = ld_ext_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    rdata_d   = 32'h0000_0000;
                    to_err_d  = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE: begin
                // Request inputs here still belong to the retiring instruction.
                state_d  = IDLE;
                cnt_d    = '0;
                to_err_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bus_req_d = 1'b0;
                to_err_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            rdata_q     <= 32'h0000_0000;
            to_err_q    <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rdata_q     <= rdata_d;
            to_err_q    <= to_err_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    // Stall and error must react in the request cycle itself; rst_n masks them.
    assign lsu_stall = rst_n && (((state_q == IDLE) && req_s && legal_s) || (state_q == BUSY));
    assign lsu_err   = rst_n && (((state_q == IDLE) && req_s && !legal_s) ||
                                 ((state_q == DONE) && to_err_q));

    assign lsu_rdata = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule
